// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains bytes from the read side of a FIFO and sends each one as an
// asynchronous UART frame: start bit (0), DATA_WIDTH data bits LSB first,
// an optional parity bit, then STOP_BITS stop bits (1). The bit period is
// timed by an internal cycle counter, so no external baud tick is needed.
//
// Parameters:
//   DATA_WIDTH - width of r_data and of the serial data field
//   BIT_CYCLES - clk cycles per bit (>= 2)
//   STOP_BITS  - 1 or 2
//   PARITY     - 0 none, 1 even, 2 odd
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   permission to start new frames (running frames finish)
//   empty      in   FIFO empty flag
//   r_data     in   FIFO head byte, valid while empty = 0
//   rd         out  FIFO pop strobe, one cycle per byte taken
//   tx         out  registered serial line, idles high
//   busy       out  high while a frame is on the line
//   frame_done out  pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 868,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  // Bit index covers both the data bits and the stop-bit count.
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;

  logic launch;
  logic bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    // Gating with reset keeps the FIFO from losing a byte during a reset cycle.
    launch     = en & ~empty & ~reset;
    bit_end    = (cyc_q == CYC_LAST);

    state_d    = state_q;
    cyc_d      = bit_end ? '0 : cyc_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    rd         = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (launch) begin
          rd      = 1'b1;
          shreg_d = r_data;
          par_d   = 1'b0;
          bit_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          par_d   = par_q ^ shreg_q[0];
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PAR: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            frame_done = 1'b1;
            bit_d      = '0;
            // Back-to-back: the next start bit follows the stop bit directly.
            if (launch) begin
              rd      = 1'b1;
              shreg_d = r_data;
              par_d   = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered, so it is decoded from the state being entered.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      S_PAR:   tx_d = (PARITY == 2) ? ~par_d : par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Four instances with BIT_CYCLES=4, DATA_WIDTH=8:
//   u0: no parity, 1 stop   u1: even parity, 1 stop
//   u2: odd parity, 1 stop  u3: no parity, 2 stops
// Each instance is fed from its own small FIFO kept in the bench. A reference
// model predicts, per instance, the whole frame as a bit list and the number
// of cycles left in the current frame; every cycle all outputs are compared.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int BC = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] empty;
  logic [3:0] rd, tx, busy, fd;
  logic [7:0] rdata [4];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(BC), .STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .empty(empty[0]), .r_data(rdata[0]),
    .rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]));
  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(BC), .STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .empty(empty[1]), .r_data(rdata[1]),
    .rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]));
  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(BC), .STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .en(en), .empty(empty[2]), .r_data(rdata[2]),
    .rd(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2]));
  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(BC), .STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .en(en), .empty(empty[3]), .r_data(rdata[3]),
    .rd(rd[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(fd[3]));

  int par_a  [4] = '{0, 1, 2, 0};
  int stop_a [4] = '{1, 1, 1, 2};

  // Bench-side FIFOs (circular buffers).
  logic [7:0] fb [4][64];
  int         head [4];
  int         cnt  [4];

  // Reference model state.
  int          rem   [4];
  int          flen  [4];
  logic [15:0] fbits [4];
  logic        rd_exp [4];

  // Outputs sampled at the falling edge.
  logic s_tx [4], s_busy [4], s_fd [4], s_rd [4];

  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_on = 1'b0;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [15:0] bits;   // bit i = i-th bit on the line
    int          nbits;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input logic [7:0] d);
    fb[g][(head[g] + cnt[g]) % 64] = d;
    cnt[g]++;
  endtask

  // Frame as the line should carry it: start, data LSB first, parity, stops.
  function automatic void build(input logic [7:0] d, input int par, input int nstop,
                                output logic [15:0] b, output int n);
    b = '0;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      b[n] = d[i];
      n++;
    end
    if (par != 0) begin
      b[n] = (par == 1) ? (^d) : ~(^d);
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      b[n] = 1'b1;
      n++;
    end
  endfunction

  // One clock cycle: present FIFO heads, check at negedge, advance at posedge.
  task automatic tick();
    int   pos;
    logic etx;
    for (int g = 0; g < 4; g++) begin
      empty[g] = (cnt[g] == 0);
      rdata[g] = (cnt[g] == 0) ? 8'h00 : fb[g][head[g]];
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      s_tx[g]   = tx[g];
      s_busy[g] = busy[g];
      s_fd[g]   = fd[g];
      s_rd[g]   = rd[g];
      rd_exp[g] = !reset && en && (cnt[g] != 0) && (rem[g] <= 1);
      if (chk_on) begin
        pos = flen[g] * BC - rem[g];
        etx = (rem[g] > 0) ? fbits[g][pos / BC] : 1'b1;
        check($sformatf("tx[%0d]", g),   32'(s_tx[g]),   32'(etx));
        check($sformatf("busy[%0d]", g), 32'(s_busy[g]), 32'(rem[g] > 0));
        check($sformatf("frame_done[%0d]", g), 32'(s_fd[g]), 32'(rem[g] == 1));
        check($sformatf("rd[%0d]", g),   32'(s_rd[g]),   32'(rd_exp[g]));
      end
    end
    @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      if (reset) begin
        rem[g] = 0;
      end else if (rd_exp[g]) begin
        build(fb[g][head[g]], par_a[g], stop_a[g], fbits[g], flen[g]);
        rem[g] = flen[g] * BC;
      end else if (rem[g] > 0) begin
        rem[g]--;
      end
      if (s_rd[g] && cnt[g] > 0) begin
        head[g] = (head[g] + 1) % 64;
        cnt[g]--;
      end
    end
    #1;
  endtask

  task automatic wait_rd(input int g, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      tick();
      if (s_rd[g]) ok = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   nrd, cyc, bad, idx;
    logic started, done;
    nrd = 0; cyc = 0; bad = 0;
    started = 1'b0; done = 1'b0;
    push(v.dut, v.data);
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      if (started) begin
        cyc++;
        idx = (cyc - 1) / BC;
        if (idx >= v.nbits) bad++;
        else if (s_tx[v.dut] !== v.bits[idx]) bad++;
        if (s_fd[v.dut]) done = 1'b1;
      end
      if (s_rd[v.dut]) begin
        nrd++;
        started = 1'b1;
      end
    end
    check($sformatf("vec_done[%0h]", v.data), 32'(done), 32'd1);
    check($sformatf("vec_len[%0h]", v.data),  32'(cyc),  32'(v.nbits * BC));
    check($sformatf("vec_bits[%0h]", v.data), 32'(bad),  32'd0);
    check($sformatf("vec_rd[%0h]", v.data),   32'(nrd),  32'd1);
    tick();
    tick();
  endtask

  initial begin
    logic ok;
    int   n_rd, n_busy, n_low, busy_cnt, hi_cnt, fd1, rd2;
    logic drained;

    tbl[0] = '{dut: 0, data: 8'hA5, bits: 16'h034A, nbits: 10};
    tbl[1] = '{dut: 1, data: 8'h07, bits: 16'h060E, nbits: 11};
    tbl[2] = '{dut: 2, data: 8'h07, bits: 16'h040E, nbits: 11};
    tbl[3] = '{dut: 3, data: 8'h3C, bits: 16'h0678, nbits: 11};
    tbl[4] = '{dut: 0, data: 8'h00, bits: 16'h0200, nbits: 10};
    tbl[5] = '{dut: 1, data: 8'hFF, bits: 16'h05FE, nbits: 11};
    tbl[6] = '{dut: 2, data: 8'hFF, bits: 16'h07FE, nbits: 11};

    for (int g = 0; g < 4; g++) begin
      head[g] = 0; cnt[g] = 0; rem[g] = 0; flen[g] = 0;
      fbits[g] = '0; rd_exp[g] = 1'b0;
    end

    // Reset, then idle with en=1 and every FIFO empty.
    reset = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    reset = 1'b0;
    en    = 1'b1;
    n_rd = 0; n_busy = 0; n_low = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (s_rd[0])   n_rd++;
      if (s_busy[0]) n_busy++;
      if (!s_tx[0])  n_low++;
    end
    check("idle_rd",   32'(n_rd),   32'd0);
    check("idle_busy", 32'(n_busy), 32'd0);
    check("idle_tx",   32'(n_low),  32'd0);

    // Single frames with hand-derived line patterns.
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Back-to-back 0x00 then 0xFF on the no-parity instance.
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_rd(0, ok);
    check("b2b_launch", 32'(ok), 32'd1);
    busy_cnt = 0; hi_cnt = 0; fd1 = 0; rd2 = 0;
    for (int rel = 1; rel <= 85; rel++) begin
      tick();
      if (s_busy[0]) busy_cnt++;
      if (rel <= 41 && s_tx[0]) hi_cnt++;
      if (s_fd[0] && fd1 == 0) fd1 = rel;
      if (s_rd[0] && rd2 == 0) rd2 = rel;
    end
    check("b2b_busy",   32'(busy_cnt), 32'd80);
    check("b2b_fd1",    32'(fd1),      32'd40);
    check("b2b_rd2",    32'(rd2),      32'd40);
    check("b2b_gap_hi", 32'(hi_cnt),   32'd4);

    // Reset during cycle 15 of a frame with more bytes waiting.
    push(0, 8'h5A);
    push(0, 8'h33);
    push(0, 8'hC3);
    wait_rd(0, ok);
    check("rst_launch", 32'(ok), 32'd1);
    for (int t = 0; t < 14; t++) tick();
    check("rst_pending", 32'(cnt[0]), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_tx",      32'(s_tx[0]),   32'd1);
    check("rst_busy",    32'(s_busy[0]), 32'd0);
    check("rst_relaunch", 32'(s_rd[0]),  32'd1);
    check("rst_popped",  32'(cnt[0]),    32'd1);
    for (int t = 0; t < 100; t++) tick();

    // Random traffic: pushes, en toggles and rare resets.
    for (int t = 0; t < 4000; t++) begin
      int g;
      if ($urandom_range(0, 7) == 0) begin
        g = int'($urandom_range(0, 3));
        if (cnt[g] < 8) push(g, 8'($urandom));
      end
      if ($urandom_range(0, 31) == 0) en = ~en;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end

    // Drain everything that is still queued.
    reset = 1'b0;
    en    = 1'b1;
    drained = 1'b0;
    for (int t = 0; t < 600 && !drained; t++) begin
      tick();
      drained = 1'b1;
      for (int g = 0; g < 4; g++)
        if (cnt[g] != 0 || rem[g] != 0) drained = 1'b0;
    end
    check("drain", 32'(drained), 32'd1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
